// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file and its scoreboard.
// Provides the address-width helper and default address/data typedefs that
// decode and writeback use when talking to the register file.
package reg_file_pkg;

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    localparam int RfDataWidth = 32;
    localparam int RfNumRegs   = 32;
    localparam int RfAddrW     = addr_w(RfNumRegs);

    typedef logic [RfAddrW-1:0]     rf_addr_t;
    typedef logic [RfDataWidth-1:0] rf_data_t;

endpackage

// File: rtl/reg_file_mp_sb_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
// Carries read ports, write ports, scoreboard claim/flush and parity status.
interface reg_file_mp_sb_if #(
    parameter int DataWidth = 32,
    parameter int NumRegs   = 32,
    parameter int NumRead   = 2,
    parameter int NumWrite  = 2
);
    import reg_file_pkg::*;

    localparam int AddrW = addr_w(NumRegs);

    logic [NumRead*AddrW-1:0]      i_raddr;
    logic [NumRead*DataWidth-1:0]  o_rdata;
    logic [NumRead-1:0]            o_rbusy;
    logic [NumWrite-1:0]           i_we;
    logic [NumWrite*AddrW-1:0]     i_waddr;
    logic [NumWrite*DataWidth-1:0] i_wdata;
    logic                          i_claim;
    logic [AddrW-1:0]              i_claim_addr;
    logic                          i_flush;
    logic [NumRegs-1:0]            o_busy_vec;
    logic [AddrW:0]                o_busy_cnt;
    logic                          i_par_inject;
    logic [NumRead-1:0]            o_par_err;
    logic                          o_par_sticky;

    modport master (
        output i_raddr, i_we, i_waddr, i_wdata, i_claim, i_claim_addr,
               i_flush, i_par_inject,
        input  o_rdata, o_rbusy, o_busy_vec, o_busy_cnt, o_par_err, o_par_sticky
    );

    modport slave (
        input  i_raddr, i_we, i_waddr, i_wdata, i_claim, i_claim_addr,
               i_flush, i_par_inject,
        output o_rdata, o_rbusy, o_busy_vec, o_busy_cnt, o_par_err, o_par_sticky
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Busy-register scoreboard: one pending bit per register, set by decode
// claims, cleared by writeback writes, wiped by flush. Also keeps an exact
// registered popcount and reports per-read-port pending status.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NumRegs  = 32,
    parameter int NumRead  = 2,
    parameter int NumWrite = 2,
    parameter int ZeroReg  = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NumRead*addr_w(NumRegs)-1:0]     i_raddr,
    input  logic [NumWrite-1:0]                    i_we,
    input  logic [NumWrite*addr_w(NumRegs)-1:0]    i_waddr,
    input  logic                                   i_claim,
    input  logic [addr_w(NumRegs)-1:0]             i_claim_addr,
    input  logic                                   i_flush,
    output logic [NumRead-1:0]                     o_rbusy,
    output logic [NumRegs-1:0]                     o_busy_vec,
    output logic [addr_w(NumRegs):0]               o_busy_cnt
);

    localparam int AddrW = addr_w(NumRegs);

    logic [NumRegs-1:0] busy_q, busy_d;
    logic [AddrW:0]     cnt_q, cnt_d;
    logic [NumRegs-1:0] clr_vec;
    logic [NumRegs-1:0] claim_vec;

    // Registers being written back this cycle lose their pending bit.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NumWrite; w++) begin
            if (i_we[w]) begin
                clr_vec[i_waddr[w*AddrW +: AddrW]] = 1'b1;
            end
        end
    end

    // Decode claim; a hardwired-zero register can never become pending.
    always_comb begin
        claim_vec = '0;
        if (i_claim && !((ZeroReg != 0) && (i_claim_addr == '0))) begin
            claim_vec[i_claim_addr] = 1'b1;
        end
    end

    // Next pending state: flush wins, then claim, then writeback clear.
    always_comb begin
        if (i_flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_vec) | claim_vec;
        end
        cnt_d = '0;
        for (int i = 0; i < NumRegs; i++) begin
            cnt_d = cnt_d + {{AddrW{1'b0}}, busy_d[i]};
        end
    end

    // Pending bits and their count update together so they never disagree.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A read sees its register as pending unless writeback retires it now.
    always_comb begin
        o_rbusy = '0;
        for (int r = 0; r < NumRead; r++) begin
            if (!((ZeroReg != 0) && (i_raddr[r*AddrW +: AddrW] == '0))) begin
                o_rbusy[r] = busy_q[i_raddr[r*AddrW +: AddrW]]
                           & ~clr_vec[i_raddr[r*AddrW +: AddrW]];
            end
        end
    end

    assign o_busy_vec = busy_q;
    assign o_busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with write-to-read bypass and an integrated
// busy-register scoreboard. Optional per-register even parity is enabled by
// defining REG_FILE_PARITY_EN; without it the parity outputs read as zero.
module reg_file_mp_sb
    import reg_file_pkg::*;
#(
    parameter int                       DataWidth = 32,
    parameter int                       NumRegs   = 32,
    parameter int                       NumRead   = 2,
    parameter int                       NumWrite  = 2,
    parameter int                       ZeroReg   = 1,
    parameter logic [DataWidth-1:0]     EmptyReg  = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    reg_file_mp_sb_if.slave   bus
);

    localparam int AddrW = addr_w(NumRegs);

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];
    logic [NumRegs-1:0]   wr_hit;
    logic [DataWidth-1:0] wr_data [NumRegs];
    logic [AddrW-1:0]     rd_addr [NumRead];
    logic [NumRead-1:0]   rd_zero;
    logic [NumRead-1:0]   rd_bypass;

    // Resolve the winning write per register; the highest-index port wins.
    always_comb begin
        for (int a = 0; a < NumRegs; a++) begin
            wr_hit[a]  = 1'b0;
            wr_data[a] = '0;
            for (int w = 0; w < NumWrite; w++) begin
                if (bus.i_we[w] && (bus.i_waddr[w*AddrW +: AddrW] == AddrW'(a))) begin
                    wr_hit[a]  = 1'b1;
                    wr_data[a] = bus.i_wdata[w*DataWidth +: DataWidth];
                end
            end
            if ((ZeroReg != 0) && (a == 0)) begin
                wr_hit[a] = 1'b0;
            end
        end
    end

    // Next register contents: winning write data or hold.
    always_comb begin
        for (int a = 0; a < NumRegs; a++) begin
            regs_d[a] = wr_hit[a] ? wr_data[a] : regs_q[a];
        end
    end

    // Register array storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int a = 0; a < NumRegs; a++) begin
                regs_q[a] <= EmptyReg;
            end
        end else begin
            for (int a = 0; a < NumRegs; a++) begin
                regs_q[a] <= regs_d[a];
            end
        end
    end

    // Read ports: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        bus.o_rdata = '0;
        for (int r = 0; r < NumRead; r++) begin
            rd_addr[r]   = bus.i_raddr[r*AddrW +: AddrW];
            rd_zero[r]   = (ZeroReg != 0) && (rd_addr[r] == '0);
            rd_bypass[r] = wr_hit[rd_addr[r]];
            if (rd_zero[r]) begin
                bus.o_rdata[r*DataWidth +: DataWidth] = '0;
            end else if (rd_bypass[r]) begin
                bus.o_rdata[r*DataWidth +: DataWidth] = wr_data[rd_addr[r]];
            end else begin
                bus.o_rdata[r*DataWidth +: DataWidth] = regs_q[rd_addr[r]];
            end
        end
    end

    reg_file_scoreboard #(
        .NumRegs  (NumRegs),
        .NumRead  (NumRead),
        .NumWrite (NumWrite),
        .ZeroReg  (ZeroReg)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_raddr      (bus.i_raddr),
        .i_we         (bus.i_we),
        .i_waddr      (bus.i_waddr),
        .i_claim      (bus.i_claim),
        .i_claim_addr (bus.i_claim_addr),
        .i_flush      (bus.i_flush),
        .o_rbusy      (bus.o_rbusy),
        .o_busy_vec   (bus.o_busy_vec),
        .o_busy_cnt   (bus.o_busy_cnt)
    );

`ifdef REG_FILE_PARITY_EN
    logic [NumRegs-1:0] par_q, par_d;
    logic               sticky_q, sticky_d;
    logic [NumRead-1:0] par_err;

    // Stored parity follows the winning write; inject deliberately corrupts it.
    always_comb begin
        for (int a = 0; a < NumRegs; a++) begin
            par_d[a] = wr_hit[a] ? ((^wr_data[a]) ^ bus.i_par_inject) : par_q[a];
        end
    end

    // Only stored (non-bypassed, non-zero) reads can expose a parity error.
    always_comb begin
        for (int r = 0; r < NumRead; r++) begin
            par_err[r] = !rd_zero[r] && !rd_bypass[r]
                       && ((^regs_q[rd_addr[r]]) != par_q[rd_addr[r]]);
        end
        sticky_d = sticky_q | (|par_err);
    end

    // Parity bits start consistent with the reset contents; sticky clears only on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_q    <= {NumRegs{^EmptyReg}};
            sticky_q <= 1'b0;
        end else begin
            par_q    <= par_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.o_par_err    = par_err;
    assign bus.o_par_sticky = sticky_q;
`else
    logic unused_par_inject;

    assign unused_par_inject = bus.i_par_inject;
    assign bus.o_par_err     = '0;
    assign bus.o_par_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Self-checking bench for reg_file_mp_sb: an array-based reference model is
// compared against every output on each falling edge, and directed vectors
// carry hand-computed literal expectations.
module tb_reg_file_mp_sb;

    localparam int          DW    = 32;
    localparam int          NREG  = 32;
    localparam int          NRD   = 2;
    localparam int          NWR   = 2;
    localparam int          AW    = 5;
    localparam logic [31:0] EMPTY = '0;
`ifdef REG_FILE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    bit          m_bad  [NREG];
    bit          m_sticky;

    reg_file_mp_sb_if #(.DataWidth(DW), .NumRegs(NREG), .NumRead(NRD), .NumWrite(NWR)) bus ();

    reg_file_mp_sb #(
        .DataWidth (DW),
        .NumRegs   (NREG),
        .NumRead   (NRD),
        .NumWrite  (NWR),
        .ZeroReg   (1),
        .EmptyReg  (EMPTY)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int raddr_of(input int r);
        return int'(bus.i_raddr[r*AW +: AW]);
    endfunction

    function automatic bit write_hits(input int a);
        bit hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (bus.i_we[w] && int'(bus.i_waddr[w*AW +: AW]) == a) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [31:0] exp_rdata(input int a);
        logic [31:0] v = m_regs[a];
        if (a == 0) return 32'h0;
        for (int w = 0; w < NWR; w++) begin
            if (bus.i_we[w] && int'(bus.i_waddr[w*AW +: AW]) == a) v = bus.i_wdata[w*DW +: DW];
        end
        return v;
    endfunction

    function automatic bit exp_rbusy(input int a);
        return m_busy[a] && !write_hits(a);
    endfunction

    function automatic bit exp_err(input int a);
        return PAR && (a != 0) && !write_hits(a) && m_bad[a];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NREG; a++) begin
            m_regs[a] = EMPTY;
            m_busy[a] = 1'b0;
            m_bad[a]  = 1'b0;
        end
        m_sticky = 1'b0;
    endtask

    // Reference model: register contents, pending set and parity health.
    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                model_reset();
            end else begin
                for (int r = 0; r < NRD; r++) begin
                    if (exp_err(raddr_of(r))) m_sticky = 1'b1;
                end
                if (bus.i_flush) begin
                    for (int a = 0; a < NREG; a++) m_busy[a] = 1'b0;
                end else begin
                    for (int w = 0; w < NWR; w++) begin
                        if (bus.i_we[w]) m_busy[int'(bus.i_waddr[w*AW +: AW])] = 1'b0;
                    end
                    if (bus.i_claim && bus.i_claim_addr != '0) m_busy[int'(bus.i_claim_addr)] = 1'b1;
                end
                for (int w = 0; w < NWR; w++) begin
                    if (bus.i_we[w] && bus.i_waddr[w*AW +: AW] != '0) begin
                        m_regs[int'(bus.i_waddr[w*AW +: AW])] = bus.i_wdata[w*DW +: DW];
                        m_bad[int'(bus.i_waddr[w*AW +: AW])]  = PAR && bus.i_par_inject;
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge i_clk);
            begin
                logic [31:0] vec;
                int          cnt;
                vec = '0;
                cnt = 0;
                for (int a = 0; a < NREG; a++) begin
                    vec[a] = m_busy[a];
                    cnt += int'(m_busy[a]);
                end
                for (int r = 0; r < NRD; r++) begin
                    checkOutput($sformatf("model rdata%0d", r), bus.o_rdata[r*DW +: DW], exp_rdata(raddr_of(r)));
                    checkOutput($sformatf("model rbusy%0d", r), 32'(bus.o_rbusy[r]), 32'(exp_rbusy(raddr_of(r))));
                    checkOutput($sformatf("model par_err%0d", r), 32'(bus.o_par_err[r]), 32'(exp_err(raddr_of(r))));
                end
                checkOutput("model busy_vec", bus.o_busy_vec, vec);
                checkOutput("model busy_cnt", 32'(bus.o_busy_cnt), 32'(cnt));
                checkOutput("model sticky", 32'(bus.o_par_sticky), 32'(m_sticky));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                                 input int wa1, input logic [31:0] wd1, input bit claim, input int ca,
                                 input bit flush, input bit inject, input int ra0, input int ra1);
        @(posedge i_clk);
        #1;
        bus.i_we         = we;
        bus.i_waddr      = {AW'(wa1), AW'(wa0)};
        bus.i_wdata      = {wd1, wd0};
        bus.i_claim      = claim;
        bus.i_claim_addr = AW'(ca);
        bus.i_flush      = flush;
        bus.i_par_inject = inject;
        bus.i_raddr      = {AW'(ra1), AW'(ra0)};
    endtask

    task automatic idle(input int ra0, input int ra1);
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0, 1'b0, 1'b0, ra0, ra1);
    endtask

    initial begin
        bus.i_we = '0; bus.i_waddr = '0; bus.i_wdata = '0; bus.i_claim = 1'b0;
        bus.i_claim_addr = '0; bus.i_flush = 1'b0; bus.i_par_inject = 1'b0; bus.i_raddr = '0;

        // Reset state and every address reads the empty value.
        #2;
        checkOutput("reset busy_vec", bus.o_busy_vec, 32'h0);
        checkOutput("reset busy_cnt", 32'(bus.o_busy_cnt), 32'h0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            idle(a, NREG - 1 - a);
            #2;
            checkOutput("reset rdata0", bus.o_rdata[0 +: DW], EMPTY);
            checkOutput("reset rdata1", bus.o_rdata[DW +: DW], EMPTY);
        end

        // Dual write to x5: higher port wins, bypassed then stored.
        applyStimulus(2'b11, 5, 32'h11, 5, 32'h22, 1'b0, 0, 1'b0, 1'b0, 5, 5);
        #2;
        checkOutput("bypass x5 port0", bus.o_rdata[0 +: DW], 32'h22);
        checkOutput("bypass x5 port1", bus.o_rdata[DW +: DW], 32'h22);
        idle(5, 0);
        #2;
        checkOutput("stored x5", bus.o_rdata[0 +: DW], 32'h22);
        checkOutput("x0 reads zero", bus.o_rdata[DW +: DW], 32'h0);

        // Claim, claim-with-write, then clearing write on x7.
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 7, 1'b0, 1'b0, 7, 0);
        idle(7, 0);
        #2;
        checkOutput("claim x7 vec", bus.o_busy_vec, 32'h80);
        checkOutput("claim x7 cnt", 32'(bus.o_busy_cnt), 32'd1);
        checkOutput("claim x7 rbusy", 32'(bus.o_rbusy[0]), 32'd1);
        applyStimulus(2'b01, 7, 32'h77, 0, 32'h0, 1'b1, 7, 1'b0, 1'b0, 7, 0);
        #2;
        checkOutput("wr+claim x7 rbusy", 32'(bus.o_rbusy[0]), 32'd0);
        checkOutput("wr+claim x7 rdata", bus.o_rdata[0 +: DW], 32'h77);
        idle(7, 0);
        #2;
        checkOutput("wr+claim keeps busy", bus.o_busy_vec, 32'h80);
        checkOutput("wr+claim keeps cnt", 32'(bus.o_busy_cnt), 32'd1);
        applyStimulus(2'b01, 7, 32'h78, 0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 7, 0);
        #2;
        checkOutput("clearing cycle rbusy", 32'(bus.o_rbusy[0]), 32'd0);
        checkOutput("clearing cycle vec", bus.o_busy_vec, 32'h80);
        idle(7, 0);
        #2;
        checkOutput("cleared x7 vec", bus.o_busy_vec, 32'h0);
        checkOutput("cleared x7 cnt", 32'(bus.o_busy_cnt), 32'd0);
        checkOutput("cleared x7 rdata", bus.o_rdata[0 +: DW], 32'h78);

        // Several claims, then flush beats a simultaneous claim; x0 stays inert.
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 3, 1'b0, 1'b0, 3, 9);
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 4, 1'b0, 1'b0, 3, 9);
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 9, 1'b0, 1'b0, 3, 9);
        idle(3, 9);
        #2;
        checkOutput("three claims vec", bus.o_busy_vec, 32'h218);
        checkOutput("three claims cnt", 32'(bus.o_busy_cnt), 32'd3);
        checkOutput("x9 rbusy", 32'(bus.o_rbusy[1]), 32'd1);
        applyStimulus(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 10, 1'b1, 1'b0, 3, 10);
        idle(3, 10);
        #2;
        checkOutput("flush vec", bus.o_busy_vec, 32'h0);
        checkOutput("flush cnt", 32'(bus.o_busy_cnt), 32'd0);
        applyStimulus(2'b01, 0, 32'hFF, 0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 0, 0);
        #2;
        checkOutput("x0 write bypass", bus.o_rdata[0 +: DW], 32'h0);
        idle(0, 0);
        #2;
        checkOutput("x0 stored", bus.o_rdata[0 +: DW], 32'h0);
        checkOutput("x0 not busy", 32'(bus.o_rbusy[0]), 32'd0);
        checkOutput("x0 claim vec", bus.o_busy_vec, 32'h0);

        // Parity injection on x2, then a clean rewrite.
        applyStimulus(2'b01, 2, 32'hA5, 0, 32'h0, 1'b0, 0, 1'b0, 1'b1, 2, 0);
        #2;
        checkOutput("inject bypass err", 32'(bus.o_par_err[0]), 32'd0);
        idle(2, 0);
        #2;
        checkOutput("inject read err", 32'(bus.o_par_err[0]), 32'(PAR));
        checkOutput("inject read data", bus.o_rdata[0 +: DW], 32'hA5);
        checkOutput("sticky not yet", 32'(bus.o_par_sticky), 32'd0);
        idle(2, 0);
        #2;
        checkOutput("sticky set", 32'(bus.o_par_sticky), 32'(PAR));
        applyStimulus(2'b01, 2, 32'hA5, 0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 2, 0);
        idle(2, 0);
        #2;
        checkOutput("clean rewrite err", 32'(bus.o_par_err[0]), 32'd0);
        checkOutput("sticky holds", 32'(bus.o_par_sticky), 32'(PAR));

        // Five claims with writes, then an asynchronous reset mid-cycle.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b11, 20 + k, 32'h100 + 32'(k), 25 + k, 32'h200 + 32'(k),
                          1'b1, 11 + k, 1'b0, 1'b0, 20, 11);
        end
        idle(5, 20);
        #2;
        checkOutput("five busy cnt", 32'(bus.o_busy_cnt), 32'd5);
        checkOutput("five busy vec", bus.o_busy_vec, 32'h0000F800);
        checkOutput("x20 stored", bus.o_rdata[DW +: DW], 32'h100);
        @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1;
        checkOutput("async rst cnt", 32'(bus.o_busy_cnt), 32'd0);
        checkOutput("async rst vec", bus.o_busy_vec, 32'h0);
        checkOutput("async rst x5", bus.o_rdata[0 +: DW], EMPTY);
        checkOutput("async rst x20", bus.o_rdata[DW +: DW], EMPTY);
        checkOutput("async rst sticky", 32'(bus.o_par_sticky), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        idle(5, 20);
        idle(5, 20);
        #2;
        checkOutput("post rst x5", bus.o_rdata[0 +: DW], EMPTY);

        @(posedge i_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
